// File: rtl/instruction_queue.sv
// ============================================================================
//  Module      : instruction_queue
//  Description : DEPTH-entry {pc, instruction} FIFO between fetch and decode,
//                valid/ready on both sides, flush discards all entries.
//                Optional zero-latency empty-queue bypass: IQ_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_queue #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               w_empty;
    logic               w_full;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [INSTR_W-1:0] w_head_instr;
    logic [PC_W-1:0]    w_head_pc;

    always_comb begin
        w_empty  = (count_q == '0);
        w_full   = (count_q == FULL_CNT);
`ifdef IQ_BYPASS_EN
        w_bypass = w_empty & in_valid & ~flush;
`else
        w_bypass = 1'b0;
`endif
        in_ready  = ~flush & ~w_full;
        out_valid = ~flush & (~w_empty | w_bypass);

        w_push  = in_valid & in_ready;
        w_pop   = out_valid & out_ready;
        // A bypassed entry consumed in the same cycle never touches storage
        w_wr_en = w_push & ~(w_bypass & out_ready);
        w_rd_en = w_pop & ~w_empty;

        if (w_bypass) begin
            w_head_instr = in_instr;
            w_head_pc    = in_pc;
        end else begin
            w_head_instr = instr_mem_q[rd_ptr_q];
            w_head_pc    = pc_mem_q[rd_ptr_q];
        end
        out_instr = out_valid ? w_head_instr : '0;
        out_pc    = out_valid ? w_head_pc    : '0;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (w_wr_en) begin
                instr_mem_q[wr_ptr_q] <= in_instr;
                pc_mem_q[wr_ptr_q]    <= in_pc;
            end
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_queue.sv
// Randomised + directed bench for instruction_queue against a queue-based reference model.
`default_nettype none

module tb_instruction_queue;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH + 1);
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [CNT_W-1:0]   count;

    int errors = 0;
    int checks = 0;

    // Reference contents, oldest first: {pc, instr}
    logic [PC_W+INSTR_W-1:0] exp_q [$];

    instruction_queue #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference update at the clock edge
    always @(posedge clk) begin
        bit e_rdy, e_vld;
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            e_rdy = (exp_q.size() < DEPTH);
            e_vld = (exp_q.size() > 0) || (BYP && in_valid);
            if (in_valid && e_rdy) exp_q.push_back({in_pc, in_instr});
            if (e_vld && out_ready) void'(exp_q.pop_front());
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the reference
    always @(negedge clk) begin
        bit e_rdy, e_vld;
        logic [PC_W+INSTR_W-1:0] head;
        if (!reset) begin
            e_rdy = !flush && (exp_q.size() < DEPTH);
            e_vld = !flush && ((exp_q.size() > 0) || (BYP && in_valid));
            if (exp_q.size() > 0) head = exp_q[0];
            else                  head = {in_pc, in_instr};
            if (!e_vld) head = '0;
            chk("in_ready",  64'(in_ready),  64'(e_rdy));
            chk("out_valid", 64'(out_valid), 64'(e_vld));
            chk("count",     64'(count),     64'(exp_q.size()));
            chk("out_instr", 64'(out_instr), 64'(head[INSTR_W-1:0]));
            chk("out_pc",    64'(out_pc),    64'(head[PC_W+INSTR_W-1:INSTR_W]));
        end
    end

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit rdy, input bit fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_instr = 32'hDEAD; in_pc = 32'h4;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("post_reset_count", 64'(count), 64'd0);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Fill, refused fifth push, then drain
        for (int i = 0; i < 4; i++) drive(1, 32'hA0 + i, 32'h100 + 4 * i, 0, 0);
        chk("full_count", 64'(count), 64'd4);
        drive(1, 32'hA4, 32'h110, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);

        // Concurrent push/pop at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) drive(1, 32'hD0 + i, 32'h200 + 4 * i, 0, 0);
        for (int i = 2; i < 8; i++) drive(1, 32'hD0 + i, 32'h200 + 4 * i, 1, 0);
        chk("concurrent_count", 64'(count), 64'd2);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, 0);

        // Flush at count=3 with a same-cycle push
        for (int i = 0; i < 3; i++) drive(1, 32'hE0 + i, 32'h300 + 4 * i, 0, 0);
        drive(1, 32'hBB, 32'h3FC, 1, 1);
        chk("flush_count", 64'(count), 64'd0);

        // Full queue with pop and push requested together
        for (int i = 0; i < 4; i++) drive(1, 32'hF0 + i, 32'h400 + 4 * i, 0, 0);
        drive(1, 32'hF4, 32'h410, 1, 0);
        chk("full_pop_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);

        // Empty queue push with out_ready high (bypass when enabled)
        drive(1, 32'hCC, 32'h500, 1, 0);
        drive(0, 0, 0, 1, 0);

        // Randomised traffic with occasional flush and one mid-run reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                reset = 1'b1;
                drive(1, $urandom, $urandom, 1, 0);
                reset = 1'b0;
            end
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
